// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared constants for the UART TX byte feeder.
// Holds the default FIFO depth, FSM state bit indices and one-hot state type.
package uart_tx_feeder_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Bit positions of the one-hot FSM state vector
  localparam int S_IDLE      = 0;
  localparam int S_LAUNCH    = 1;
  localparam int S_WAIT_BUSY = 2;
  localparam int S_WAIT_DONE = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_LAUNCH    = 4'b0010,
    ST_WAIT_BUSY = 4'b0100,
    ST_WAIT_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem: synchronous byte FIFO with wrapping pointers and
// registered level/full/empty.
// Ports: clk, reset (async, active-high), clr (sync clear), push, pop,
// wr_data, rd_data (head byte, combinational), level, full, empty.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo_mem
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] lvl_nxt;

  // full/empty are the pre-edge values, so a write while full is
  // dropped even when a pop happens in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    lvl_nxt = level;
    unique case ({do_push, do_pop})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  // Storage is not reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= lvl_nxt;
      full  <= (lvl_nxt == LW'(DEPTH));
      empty <= (lvl_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch FSM feeding the UART TX engine.
// Ports: clk, reset (async), sync_reset, wr_en/wr_data, clr_overflow,
// full/empty/level/overflow status, start_TX/SBUF_out to the TX engine,
// tx_active from it, tx_done completion pulse.
// Macro UART_TX_FEEDER_WATERMARK_EN adds watermark input and wm_irq output.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  overflow,
  output logic                  start_TX,
  output logic [7:0]            SBUF_out,
  input  logic                  tx_active,
  output logic                  tx_done
`ifdef UART_TX_FEEDER_WATERMARK_EN
  ,
  input  logic [LEVEL_BITS-1:0] watermark,
  output logic                  wm_irq
`endif
);

  state_t     state;
  logic       pop;
  logic [7:0] head;

  // Pop only when the engine is idle and we are ready to launch
  assign pop = state[S_IDLE] && !empty && !tx_active && !sync_reset;

  uart_tx_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LEVEL_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (sync_reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // start_TX is set at the pop edge so it is high exactly while the
  // FSM sits in S_LAUNCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      start_TX <= 1'b0;
      tx_done  <= 1'b0;
      SBUF_out <= 8'h00;
    end else if (sync_reset) begin
      state    <= ST_IDLE;
      start_TX <= 1'b0;
      tx_done  <= 1'b0;
      SBUF_out <= 8'h00;
    end else begin
      start_TX <= 1'b0;
      tx_done  <= 1'b0;
      unique case (1'b1)
        state[S_IDLE]: begin
          if (pop) begin
            SBUF_out <= head;
            start_TX <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        state[S_LAUNCH]: begin
          state <= ST_WAIT_BUSY;
        end
        state[S_WAIT_BUSY]: begin
          if (tx_active) begin
            state <= ST_WAIT_DONE;
          end
        end
        state[S_WAIT_DONE]: begin
          if (!tx_active) begin
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (sync_reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FEEDER_WATERMARK_EN
  logic                  armed;
  logic                  acc_push;
  logic [LEVEL_BITS-1:0] lvl_nxt;

  assign acc_push = wr_en && !full;

  // Mirror the FIFO's next level so wm_irq lines up with level
  always_comb begin
    lvl_nxt = level;
    if (acc_push && !pop) begin
      lvl_nxt = level + 1'b1;
    end else if (!acc_push && pop) begin
      lvl_nxt = level - 1'b1;
    end
  end

  // armed keeps the freshly reset empty FIFO from raising the irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed  <= 1'b0;
      wm_irq <= 1'b0;
    end else if (sync_reset) begin
      armed  <= 1'b0;
      wm_irq <= 1'b0;
    end else begin
      armed  <= armed || acc_push;
      wm_irq <= (lvl_nxt <= watermark) && (armed || acc_push);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: self-checking bench for uart_tx_feeder with a
// modelled TX engine and a byte scoreboard on start_TX.
module tb_uart_tx_feeder;

  localparam int LB = 5;
  localparam int TX_LEN = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sync_reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_overflow = 1'b0;
  logic          full;
  logic          empty;
  logic [LB-1:0] level;
  logic          overflow;
  logic          start_TX;
  logic [7:0]    SBUF_out;
  logic          tx_active = 1'b0;
  logic          tx_done;
`ifdef UART_TX_FEEDER_WATERMARK_EN
  logic [LB-1:0] watermark = '0;
  logic          wm_irq;
`endif

  uart_tx_feeder #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .sync_reset   (sync_reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .start_TX     (start_TX),
    .SBUF_out     (SBUF_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
`ifdef UART_TX_FEEDER_WATERMARK_EN
    ,
    .watermark    (watermark),
    .wm_irq       (wm_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];
  int st_q[$];
  int fl_q[$];
  bit hold_busy = 1'b1;
  bit launch_seen = 1'b0;
  bit prev_act = 1'b0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // TX engine: busy from the cycle after start_TX for TX_LEN cycles
  always @(posedge clk) begin
    #1;
    if (launch_seen) busy_cnt = TX_LEN;
    launch_seen = start_TX;
    if (busy_cnt > 0) begin
      busy_cnt--;
      tx_active = 1'b1;
    end else begin
      tx_active = hold_busy;
    end
  end

  // Scoreboard and pulse monitor
  always @(negedge clk) begin
    if (start_TX) begin
      start_cnt++;
      st_q.push_back(cyc);
      if (exp_q.size() == 0) chk("sbuf_unexpected", 1, 0);
      else chk("sbuf", SBUF_out, exp_q.pop_front());
    end
    if (tx_done) done_cnt++;
    if (prev_act && !tx_active) fl_q.push_back(cyc);
    prev_act = tx_active;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] b, input bit acc);
    wr_en = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    chk("done_wait", done_cnt >= target, 1);
    repeat (3) tick();
  endtask

  typedef struct {
    logic          wr;
    logic [7:0]    d;
    logic          clr;
    logic          acc;
    logic [LB-1:0] lvl;
    logic          fu;
    logic          ov;
  } vec_t;

  vec_t tv[20];

  initial begin
    int base;
    int sbase;
    // Fill table: 17 writes into 16-deep FIFO, then overflow clear cases
    for (int i = 0; i < 17; i++) begin
      tv[i].wr  = 1'b1;
      tv[i].d   = 8'(8'h10 + i);
      tv[i].clr = 1'b0;
      tv[i].acc = (i < 16);
      tv[i].lvl = LB'((i < 16) ? i + 1 : 16);
      tv[i].fu  = (i >= 15);
      tv[i].ov  = (i == 16);
    end
    tv[17] = '{1'b0, 8'h00, 1'b1, 1'b0, LB'(16), 1'b1, 1'b0};
    tv[18] = '{1'b1, 8'hEE, 1'b1, 1'b0, LB'(16), 1'b1, 1'b1};
    tv[19] = '{1'b0, 8'h00, 1'b1, 1'b0, LB'(16), 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_start", start_TX, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_sbuf", SBUF_out, 8'h00);
`ifdef UART_TX_FEEDER_WATERMARK_EN
    chk("rst_wm", wm_irq, 0);
`endif
    reset = 1'b0;
    tick();
    tick();

    // Fill/overflow table with the engine held busy
    for (int i = 0; i < 20; i++) begin
      wr_en = tv[i].wr;
      wr_data = tv[i].d;
      clr_overflow = tv[i].clr;
      if (tv[i].acc) exp_q.push_back(tv[i].d);
      tick();
      wr_en = 1'b0;
      clr_overflow = 1'b0;
      chk($sformatf("tv%0d_level", i), level, tv[i].lvl);
      chk($sformatf("tv%0d_full", i), full, tv[i].fu);
      chk($sformatf("tv%0d_empty", i), empty, 0);
      chk($sformatf("tv%0d_ovf", i), overflow, tv[i].ov);
    end
    chk("held_no_start", start_cnt, 0);
    hold_busy = 1'b0;
    wait_done(16);
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_starts", start_cnt, 16);
    chk("drain_sb", exp_q.size(), 0);

    // Single byte latency
    base = done_cnt;
    wr(8'h55, 1'b1);
    chk("sb_empty0", empty, 0);
    chk("sb_start_n", start_TX, 0);
    tick();
    chk("sb_start_n1", start_TX, 1);
    chk("sb_sbuf", SBUF_out, 8'h55);
    tick();
    chk("sb_start_off", start_TX, 0);
    chk("sb_hold", SBUF_out, 8'h55);
    wait_done(base + 1);
    chk("sb_one_done", done_cnt, base + 1);
    chk("sb_empty", empty, 1);
    chk("sb_level", level, 0);

    // Burst of four with gap measurement
    base = done_cnt;
    sbase = start_cnt;
    st_q.delete();
    fl_q.delete();
    for (int i = 0; i < 4; i++) wr(8'(8'hA0 + i), 1'b1);
    wait_done(base + 4);
    chk("burst_done", done_cnt, base + 4);
    chk("burst_starts", start_cnt, sbase + 4);
    chk("burst_nst", st_q.size(), 4);
    chk("burst_nfl", fl_q.size(), 4);
    if (st_q.size() == 4 && fl_q.size() == 4) begin
      for (int k = 1; k < 4; k++)
        chk($sformatf("burst_gap%0d", k), st_q[k] - fl_q[k-1], 2);
    end

    // Simultaneous push and pop at level 1
    base = done_cnt;
    hold_busy = 1'b1;
    tick();
    tick();
    wr(8'h11, 1'b1);
    chk("pp_level1", level, 1);
    hold_busy = 1'b0;
    tick();
    chk("pp_idle", tx_active, 0);
    wr(8'h22, 1'b1);
    chk("pp_level", level, 1);
    chk("pp_start", start_TX, 1);
    chk("pp_sbuf", SBUF_out, 8'h11);
    wait_done(base + 2);
    chk("pp_empty", empty, 1);

    // sync_reset in S_WAIT_DONE with three queued bytes
    base = done_cnt;
    sbase = start_cnt;
    for (int i = 0; i < 4; i++) wr(8'(8'h30 + i), 1'b1);
    tick();
    tick();
    chk("sr_level3", level, 3);
    chk("sr_busy", tx_active, 1);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    exp_q.delete();
    chk("sr_level", level, 0);
    chk("sr_empty", empty, 1);
    chk("sr_start", start_TX, 0);
    repeat (15) tick();
    chk("sr_no_done", done_cnt, base);
    chk("sr_starts", start_cnt, sbase + 1);
    wr(8'h77, 1'b1);
    tick();
    chk("sr_idle_start", start_TX, 1);
    wait_done(base + 1);

    // Async reset mid-burst
    base = done_cnt;
    for (int i = 0; i < 3; i++) wr(8'(8'hC0 + i), 1'b1);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("ar_level", level, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_start", start_TX, 0);
    chk("ar_sbuf", SBUF_out, 8'h00);
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("ar_no_done", done_cnt, base);
    chk("ar_empty2", empty, 1);

`ifdef UART_TX_FEEDER_WATERMARK_EN
    base = done_cnt;
    watermark = LB'(2);
    hold_busy = 1'b1;
    tick();
    tick();
    chk("wm_unarmed", wm_irq, 0);
    for (int i = 0; i < 5; i++) begin
      wr(8'(8'hE0 + i), 1'b1);
      chk($sformatf("wm_fill%0d", i), wm_irq, (i < 2));
    end
    hold_busy = 1'b0;
    wait_done(base + 5);
    chk("wm_drained", wm_irq, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Upstream stage for the UART transmitter: byte FIFO between the CPU peripheral bus and the UART TX engine. Accepts bus writes, then pops bytes one at a time and drives the TX engine's start/data handshake, gated by that engine's tx_active status. Gives the CPU back-to-back transmission without polling per byte, with full/empty/level status and a sticky overflow flag.

Parameters:
FIFO_DEPTH, 16, entry count; power of two, 2..256
LEVEL_BITS, $clog2(FIFO_DEPTH)+1, width of level output

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
sync_reset  in  1  synchronous clear of FIFO, FSM and flags
wr_en  in  1  push wr_data this cycle
wr_data  in  8  byte to transmit
clr_overflow  in  1  clears overflow flag
full  out  1  FIFO holds FIFO_DEPTH bytes
empty  out  1  FIFO holds 0 bytes
level  out  LEVEL_BITS  current occupancy
overflow  out  1  sticky: a write was dropped while full
start_TX  out  1  one-cycle launch pulse to TX engine
SBUF_out  out  8  byte for TX engine; valid and stable while start_TX=1
tx_active  in  1  TX engine busy flag (high from cycle after start_TX until stop bit done)
tx_done  out  1  one-cycle pulse when a launched byte completes

Behaviour:
- Interface decided: one clock clk; reset is asynchronous and active-high, named reset.
- Reset (async) and sync_reset: pointers/level=0, empty=1, full=0, overflow=0, start_TX=0, tx_done=0, SBUF_out=0x00, FSM=S_IDLE. sync_reset mid-transmission abandons the byte; no tx_done pulse is issued.
- Write: wr_en && !full stores at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH; level/empty/full update at the same edge. wr_en && full: byte dropped, overflow<=1.
- overflow: set wins over clr_overflow in the same cycle.
- Pop and push in the same cycle: level unchanged. full is the pre-edge value; a write while full is dropped even if a pop occurs that cycle.
- FSM states (one-hot):
  S_IDLE: if !empty && !tx_active -> SBUF_out<=mem[rd_ptr], rd_ptr++, level--, go S_LAUNCH; else stay.
  S_LAUNCH: start_TX=1 for exactly this cycle; go S_WAIT_BUSY.
  S_WAIT_BUSY: when tx_active=1 go S_WAIT_DONE; else stay (no timeout).
  S_WAIT_DONE: when tx_active=0 assert tx_done for one cycle, go S_IDLE.
- Latency: write at edge N into an empty FIFO with the FSM idle -> empty=0 after N; pop at N+1; start_TX high during the cycle after N+1, i.e. cycle N+2.
- Back-to-back bytes: minimum 1 idle cycle between tx_active falling and the next start_TX.
- SBUF_out holds the last launched byte until the next pop.
- start_TX and tx_done are registered outputs (no combinational path from inputs).

Optional Feature:
Macro UART_TX_FEEDER_WATERMARK_EN. When defined, adds input watermark[LEVEL_BITS-1:0] and output wm_irq. wm_irq is registered and equals (level <= watermark) && !empty_was_caused_by_reset, i.e. it is high whenever level <= watermark after at least one write since the last reset/sync_reset. It is used to refill the FIFO by interrupt. When not defined, neither port exists and no extra logic is built.

Decomposition:
- Package uart_tx_feeder_pkg: state index constants S_IDLE=0, S_LAUNCH=1, S_WAIT_BUSY=2, S_WAIT_DONE=3; default FIFO_DEPTH.
- Sub-module uart_tx_fifo_mem: a synchronous FIFO with storage array, wrapping pointers, level, full and empty. It has no knowledge of the UART. The top level holds the FSM and the handshake.

Test Plan:
- Single byte: write 0x55 into an idle, empty FIFO -> start_TX=1 exactly 2 cycles later with SBUF_out=0x55. Model TX engine with tx_active high for 10 cycles -> one tx_done pulse, then empty=1 and level=0.
- Burst: write 0xA0..0xA3 on consecutive cycles -> four start_TX pulses with SBUF_out in order 0xA0,0xA1,0xA2,0xA3. Each pulse follows the previous tx_active fall by 2 cycles. Exactly 4 tx_done pulses.
- Full/overflow: hold tx_active=1 and write 17 bytes with FIFO_DEPTH=16 -> full=1 after the 16th write, 17th byte dropped, overflow=1. clr_overflow -> overflow=0. Bytes drained afterwards are exactly the first 16.
- Simultaneous push/pop: level=1, write on the same cycle the FSM pops -> level stays 1 and the new byte is sent next.
- sync_reset with FSM in S_WAIT_DONE and level=3 -> next cycle level=0, empty=1, FSM idle, no tx_done pulse. Async reset asserted mid-burst gives the same result immediately.
- With UART_TX_FEEDER_WATERMARK_EN, watermark=2, write 5 bytes and drain -> wm_irq rises when level reaches 2 and stays high while level is ≤2.
